// File: rtl/loader_pkg.sv
// Shared state encoding, byte-geometry constants and write-port struct for imem_loader.
// Combinational helpers only; no latency, no flow control of their own.
package loader_pkg;

  localparam int WORD_BYTES = 4;
  localparam int LEN_BYTES  = 2;
  localparam int LEN_W      = LEN_BYTES * 8;
  localparam int WORD_W     = WORD_BYTES * 8;

  typedef logic [2:0] state_t;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LEN0  = 3'd1;
  localparam logic [2:0] S_LEN1  = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_CHK   = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;
  localparam logic [2:0] S_ERR   = 3'd7;

  typedef struct packed {
    logic [31:0]       addr;
    logic [WORD_W-1:0] data;
  } imem_wr_t;

  // States in which the loader consumes stream bytes.
  function automatic logic takes_byte(input state_t s);
    return (s == S_LEN0) || (s == S_LEN1) || (s == S_DATA) || (s == S_CHK);
  endfunction

  // A session may (re)start only from a resting state.
  function automatic logic is_resting(input state_t s);
    return (s == S_IDLE) || (s == S_DONE) || (s == S_ERR);
  endfunction

endpackage

// File: rtl/word_assembler.sv
// Packs accepted stream bytes little-endian into a word; word/word_complete are combinational with the byte.
// No backpressure: packs on every byte_en, clear restarts at byte 0.
module word_assembler
  import loader_pkg::*;
(
  input  logic              clk,
  input  logic              areset,
  input  logic              clear,
  input  logic              byte_en,
  input  logic [7:0]        byte_data,
  output logic [WORD_W-1:0] word,
  output logic              word_complete
);

  localparam int IDX_W = $clog2(WORD_BYTES);

  logic [IDX_W-1:0]  idx;
  logic [WORD_W-1:0] pack;

  // The incoming byte is merged in so the finished word is usable in the same cycle.
  always_comb begin
    word = pack;
    word[{idx, 3'b000} +: 8] = byte_data;
  end

  assign word_complete = byte_en && (idx == IDX_W'(WORD_BYTES - 1));

  always_ff @(posedge clk) begin
    if (!areset || clear) begin
      idx  <= '0;
      pack <= '0;
    end else if (byte_en) begin
      idx  <= idx + 1'b1;
      pack <= word;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed byte stream into instruction memory, one imem write per 4 bytes, core held meanwhile.
// byte_ready drops in IDLE/WRITE/DONE/ERR to stall the source; LOADER_CHECKSUM_EN adds a trailing XOR byte check.
module imem_loader
  import loader_pkg::*;
#(
  parameter int          DEPTH     = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
)
(
  input  logic        clk,
  input  logic        areset,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        core_hold,
  output logic        done,
  output logic        err
);

  typedef logic [LEN_W:0] len_ext_t;
  localparam len_ext_t DEPTH_EXT = len_ext_t'(DEPTH);

`ifdef LOADER_CHECKSUM_EN
  localparam state_t S_TAIL = S_CHK;
`else
  localparam state_t S_TAIL = S_DONE;
`endif

  state_t            state;
  logic [LEN_W-1:0]  len;
  logic [LEN_W-1:0]  len_next;
  logic [LEN_W-1:0]  word_cnt;
  imem_wr_t          wr;
  logic              xfer;
  logic              session_clear;
  logic              asm_complete;
  logic [WORD_W-1:0] asm_word;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        chk;
`endif

  assign byte_ready    = takes_byte(state);
  assign xfer          = byte_valid && byte_ready;
  assign session_clear = start && is_resting(state);
  assign len_next      = {byte_data, len[7:0]};

  assign imem_we    = (state == S_WRITE);
  assign imem_addr  = wr.addr;
  assign imem_wdata = wr.data;
  assign core_hold  = !((state == S_IDLE) || (state == S_DONE));
  assign done       = (state == S_DONE);
  assign err        = (state == S_ERR);

  word_assembler u_asm (
    .clk           (clk),
    .areset        (areset),
    .clear         (session_clear),
    .byte_en       (xfer && (state == S_DATA)),
    .byte_data     (byte_data),
    .word          (asm_word),
    .word_complete (asm_complete)
  );

  always_ff @(posedge clk) begin
    if (!areset) begin
      state    <= S_IDLE;
      len      <= '0;
      word_cnt <= '0;
      wr.addr  <= BASE_ADDR;
      wr.data  <= '0;
`ifdef LOADER_CHECKSUM_EN
      chk      <= '0;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state    <= S_LEN0;
            len      <= '0;
            word_cnt <= '0;
`ifdef LOADER_CHECKSUM_EN
            chk      <= '0;
`endif
          end
        end
        S_LEN0: begin
          if (xfer) begin
            len[7:0] <= byte_data;
            state    <= S_LEN1;
          end
        end
        S_LEN1: begin
          if (xfer) begin
            len <= len_next;
            if (len_next == '0)
              state <= S_TAIL;
            else if ({1'b0, len_next} > DEPTH_EXT)
              state <= S_ERR;
            else
              state <= S_DATA;
          end
        end
        S_DATA: begin
          if (xfer) begin
`ifdef LOADER_CHECKSUM_EN
            chk <= chk ^ byte_data;
`endif
            // Address and data are latched here so they sit stable for the whole WRITE cycle.
            if (asm_complete) begin
              wr.addr <= BASE_ADDR + 32'({word_cnt, 2'b00});
              wr.data <= asm_word;
              state   <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          word_cnt <= word_cnt + 1'b1;
          state    <= ((word_cnt + 1'b1) < len) ? S_DATA : S_TAIL;
        end
        S_CHK: begin
`ifdef LOADER_CHECKSUM_EN
          if (xfer)
            state <= (byte_data == chk) ? S_DONE : S_ERR;
`else
          state <= S_IDLE;
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed, table-driven bench for imem_loader; build with LOADER_CHECKSUM_EN to exercise the checksum byte.
module tb_imem_loader;

`ifdef LOADER_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif

  logic        clk = 1'b0;
  logic        areset;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        core_hold;
  logic        done;
  logic        err;

  always #5 clk = ~clk;

  imem_loader dut (
    .clk        (clk),
    .areset     (areset),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_hold  (core_hold),
    .done       (done),
    .err        (err)
  );

  int checks   = 0;
  int failures = 0;

  logic [31:0] wa[$];
  logic [31:0] wd[$];

  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wa.push_back(imem_addr);
      wd.push_back(imem_wdata);
    end
  end

  typedef struct {
    string       name;
    int          n;
    logic [7:0]  b[12];
    bit          gap;
    int          exp_wr;
    logic [31:0] a0, d0, a1, d1;
    logic        ed, ee, eh;
  } vec_t;

  vec_t vecs[6];
  localparam int NV = 5 + CK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 32'hxxxx_xxxx;
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int n = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (byte_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=not_accepted required=accepted byte=%h", b);
    end else begin
      @(negedge clk);
    end
    byte_valid = 1'b0;
    if (gap) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_vec(input int i);
    wa.delete();
    wd.delete();
    pulse_start();
    for (int k = 0; k < vecs[i].n; k++) send_byte(vecs[i].b[k], vecs[i].gap);
    repeat (3) @(negedge clk);
    check({vecs[i].name, "_nwr"}, 32'(wa.size()), 32'(vecs[i].exp_wr));
    if (vecs[i].exp_wr > 0) begin
      check({vecs[i].name, "_a0"}, qget(wa, 0), vecs[i].a0);
      check({vecs[i].name, "_d0"}, qget(wd, 0), vecs[i].d0);
    end
    if (vecs[i].exp_wr > 1) begin
      check({vecs[i].name, "_a1"}, qget(wa, 1), vecs[i].a1);
      check({vecs[i].name, "_d1"}, qget(wd, 1), vecs[i].d1);
    end
    check({vecs[i].name, "_done"}, 32'(done), 32'(vecs[i].ed));
    check({vecs[i].name, "_err"}, 32'(err), 32'(vecs[i].ee));
    check({vecs[i].name, "_hold"}, 32'(core_hold), 32'(vecs[i].eh));
    check({vecs[i].name, "_rdy"}, 32'(byte_ready), 32'(1'b0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // XOR of 13,93,10 = 90; of EF,BE,AD,DE = 22.
    vecs[0] = '{name:"two_words", n:10+CK,
                b:'{8'h02,8'h00,8'h13,8'h00,8'h00,8'h00,8'h93,8'h00,8'h10,8'h00,8'h90,8'h00},
                gap:1'b0, exp_wr:2, a0:32'h0, d0:32'h0000_0013, a1:32'h4, d1:32'h0010_0093,
                ed:1'b1, ee:1'b0, eh:1'b0};
    vecs[1] = vecs[0];
    vecs[1].name = "two_words_gap";
    vecs[1].gap  = 1'b1;
    vecs[2] = '{name:"too_long", n:2,
                b:'{8'h41,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00},
                gap:1'b0, exp_wr:0, a0:32'h0, d0:32'h0, a1:32'h0, d1:32'h0,
                ed:1'b0, ee:1'b1, eh:1'b1};
    vecs[3] = '{name:"zero_len", n:2+CK,
                b:'{8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00},
                gap:1'b0, exp_wr:0, a0:32'h0, d0:32'h0, a1:32'h0, d1:32'h0,
                ed:1'b1, ee:1'b0, eh:1'b0};
    vecs[4] = '{name:"one_word", n:6+CK,
                b:'{8'h01,8'h00,8'hEF,8'hBE,8'hAD,8'hDE,8'h22,8'h00,8'h00,8'h00,8'h00,8'h00},
                gap:1'b0, exp_wr:1, a0:32'h0, d0:32'hDEAD_BEEF, a1:32'h0, d1:32'h0,
                ed:1'b1, ee:1'b0, eh:1'b0};
    vecs[5] = vecs[0];
    vecs[5].name  = "bad_chk";
    vecs[5].n     = 11;
    vecs[5].b[10] = 8'h91;
    vecs[5].ed    = 1'b0;
    vecs[5].ee    = 1'b1;
    vecs[5].eh    = 1'b1;

    areset     = 1'b0;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    repeat (2) @(negedge clk);
    areset = 1'b1;
    @(negedge clk);
    check("rst_rdy",   32'(byte_ready), 32'(1'b0));
    check("rst_we",    32'(imem_we),    32'(1'b0));
    check("rst_addr",  imem_addr,       32'h0);
    check("rst_wdata", imem_wdata,      32'h0);
    check("rst_hold",  32'(core_hold),  32'(1'b0));
    check("rst_done",  32'(done),       32'(1'b0));
    check("rst_err",   32'(err),        32'(1'b0));

    for (int i = 0; i < NV; i++) run_vec(i);

    // start pulse inside DATA must not restart the session.
    wa.delete();
    wd.delete();
    pulse_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'hAA, 1'b0);
    pulse_start();
    send_byte(8'hBB, 1'b0);
    send_byte(8'hCC, 1'b0);
    send_byte(8'hDD, 1'b0);
    if (CK == 1) send_byte(8'h00, 1'b0);
    repeat (3) @(negedge clk);
    check("mid_start_nwr",  32'(wa.size()), 32'd1);
    check("mid_start_d0",   qget(wd, 0),    32'hDDCC_BBAA);
    check("mid_start_done", 32'(done),      32'(1'b1));

    // N == DEPTH is the largest legal program; word k is four copies of byte k.
    wa.delete();
    wd.delete();
    pulse_start();
    send_byte(8'h40, 1'b0);
    send_byte(8'h00, 1'b0);
    for (int k = 0; k < 64; k++)
      for (int j = 0; j < 4; j++) send_byte(8'(k), 1'b0);
    if (CK == 1) send_byte(8'h00, 1'b0);
    repeat (3) @(negedge clk);
    check("full_nwr",  32'(wa.size()), 32'd64);
    check("full_a0",   qget(wa, 0),    32'h0);
    check("full_a63",  qget(wa, 63),   32'h0000_00FC);
    check("full_d63",  qget(wd, 63),   32'h3F3F_3F3F);
    check("full_done", 32'(done),      32'(1'b1));

    // Reset after the sixth data byte: only word 0 survives.
    wa.delete();
    wd.delete();
    pulse_start();
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h13, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h93, 1'b0);
    send_byte(8'h00, 1'b0);
    areset = 1'b0;
    @(negedge clk);
    check("mrst_hold", 32'(core_hold), 32'(1'b0));
    check("mrst_rdy",  32'(byte_ready), 32'(1'b0));
    check("mrst_addr", imem_addr,      32'h0);
    check("mrst_wdat", imem_wdata,     32'h0);
    areset = 1'b1;
    repeat (4) @(negedge clk);
    check("mrst_nwr",  32'(wa.size()), 32'd1);
    check("mrst_d0",   qget(wd, 0),    32'h0000_0013);
    check("mrst_we",   32'(imem_we),   32'(1'b0));
    run_vec(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
